add_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-bit `ripple_carry_adder` among `NUM_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one request, registers the sum and carry, and returns them with the requester's ID under a second valid/ready handshake. It sits between the client blocks and the single adder instance, so the design needs only one adder.

---
 rtl/add_arb_pkg.sv | 45 ++++
 rtl/ripple_carry_adder.sv | 27 ++
 rtl/add_arbiter.sv | 120 ++++++++++++
 tb/tb_add_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types and helpers for add_arbiter.
//   add_arb_state_t : arbiter FSM state (IDLE, RESP)
//   ADD_W           : operand / sum width of the shared adder
//   MAX_REQ, IDX_W  : largest supported requester count and its index width
//   rr_pick()       : round-robin winner search over a valid vector
package add_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } add_arb_state_t;

  localparam int ADD_W   = 8;
  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan num_req entries of valid starting at ptr, wrapping to 0 after
  // num_req-1. The first set bit wins. With ptr=0 this degenerates to
  // lowest-index-first.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 num_req);
    rr_pick_t r;
    int       k;
    r = '0;
    k = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req && !r.found) begin
        k = int'(ptr) + i;
        if (k >= num_req) k = k - num_req;
        if (valid[k[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: W-bit unsigned adder, carry rippling from bit 0, no
// carry-in.
//   a, b  : operands
//   sum   : a + b modulo 2**W
//   c_out : carry out of the top bit
module ripple_carry_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic cy;

  always_comb begin
    cy  = 1'b0;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: shares one ripple_carry_adder among NUM_REQ requesters.
// A grant in IDLE captures the winner's sum/carry/id into result registers;
// the result is then held in RESP until the consumer accepts it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is a one-hot grant derived combinationally from
// req_valid, ptr and state (never from rsp_ready); rsp_valid is high exactly
// while the FSM is in RESP and the result outputs are stable during that time.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester request handshake (one bit each)
//   req_a, req_b      : packed 8-bit operands, requester i at [8i+7:8i]
//   rsp_valid/ready   : result handshake
//   rsp_id            : owner of the held result
//   rsp_sum, rsp_c_out: registered a+b and its carry
//
// Build option: define ADD_ARB_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins, no rotating pointer); default is round-robin.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [7:0]             rsp_sum,
  output logic                   rsp_c_out
);

  add_arb_state_t     state, state_nxt;
  logic [MAX_REQ-1:0] valid_pad;
  rr_pick_t           pick;
  logic [ID_W-1:0]    win;
  logic               grant;
  logic [ADD_W-1:0]   a_sel, b_sel, sum;
  logic               c_out;

  assign valid_pad = MAX_REQ'(req_valid);

`ifdef ADD_ARB_FIXED_PRIO_EN
  assign pick = rr_pick(valid_pad, '0, NUM_REQ);
`else
  logic [ID_W-1:0] ptr;
  assign pick = rr_pick(valid_pad, IDX_W'(ptr), NUM_REQ);
`endif

  assign win = ID_W'(pick.idx);

  // Next state and grant. A grant only ever happens in IDLE, so the cycle in
  // which a response is accepted never grants.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (pick.found) begin
          grant     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && !rst && (win == ID_W'(i));
    end
  end

  // Operand mux in front of the single shared adder.
  assign a_sel = req_a[int'(win)*ADD_W +: ADD_W];
  assign b_sel = req_b[int'(win)*ADD_W +: ADD_W];

  ripple_carry_adder #(.W(ADD_W)) u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .sum  (sum),
    .c_out(c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_sum   <= '0;
      rsp_c_out <= 1'b0;
      rsp_id    <= '0;
`ifndef ADD_ARB_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (grant) begin
        rsp_sum   <= sum;
        rsp_c_out <= c_out;
        rsp_id    <= win;
`ifndef ADD_ARB_FIXED_PRIO_EN
        // Next search starts just past the winner.
        ptr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
`endif
      end
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: self-checking bench for add_arbiter (NUM_REQ=4).
// Expected results {id, carry, sum} are pushed to exp_q whenever a grant is
// expected, and popped by a response monitor when rsp_valid & rsp_ready.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_add_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = IW + 9;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_sum;
  logic           rsp_c_out;

  logic [7:0]     op_a [N];
  logic [7:0]     op_b [N];

  logic [EW-1:0]  exp_q [$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             n_push  = 0;
  int             n_rsp   = 0;

  // clock / reset
  always #5 clk = ~clk;

  add_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .rsp_c_out(rsp_c_out)
  );

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = op_a[i];
      req_b[8*i +: 8] = op_b[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference result for requester id from its current operands.
  function automatic logic [EW-1:0] model(input int id);
    logic [8:0] s;
    s = {1'b0, op_a[id]} + {1'b0, op_b[id]};
    return {IW'(id), s[8], s[7:0]};
  endfunction

  // One cycle of stimulus: drive after the edge, check on the falling edge.
  task automatic step(input logic r, input logic [N-1:0] valid, input logic rr,
                      input logic [N-1:0] exp_ready, input logic exp_rv,
                      input string tag);
    @(posedge clk); #1;
    rst       = r;
    req_valid = valid;
    rsp_ready = rr;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    check({tag, "_rvalid"}, 32'(rsp_valid), 32'(exp_rv));
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        exp_q.push_back(model(i));
        n_push++;
      end
    end
  endtask

  // Response monitor: scoreboard pop on every accepted result.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_sum", 32'(rsp_sum), 32'(e[7:0]));
        check("rsp_c_out", 32'(rsp_c_out), 32'(e[8]));
        check("rsp_id", 32'(rsp_id), 32'(e[EW-1:9]));
        n_rsp++;
      end
    end
  end

  initial begin
    int          fair_order [6];
    logic [N-1:0] oh;
    int          id;

    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 8'(i * 17 + 3);
      op_b[i] = 8'(i * 29 + 5);
    end

    // 1. reset values with every requester valid
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "rst");
      check("rst_sum", 32'(rsp_sum), 32'(0));
      check("rst_c_out", 32'(rsp_c_out), 32'(0));
      check("rst_id", 32'(rsp_id), 32'(0));
    end

    // 2. single request from requester 2
    op_a[2] = 8'd27; op_b[2] = 8'd13;
    step(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, "single");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "single_rsp");
    check("single_sum40", 32'(rsp_sum), 32'(40));

    // 3. carry and wrap
    op_a[0] = 8'd200; op_b[0] = 8'd100;
    step(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, "carry");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "carry_rsp");
    check("carry_sum44", 32'(rsp_sum), 32'(44));
    check("carry_c1", 32'(rsp_c_out), 32'(1));
    op_a[3] = 8'd255; op_b[3] = 8'd1;
    step(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, "wrap");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "wrap_rsp");
    check("wrap_sum0", 32'(rsp_sum), 32'(0));
    check("wrap_c1", 32'(rsp_c_out), 32'(1));

    // random single requests
    for (int k = 0; k < 8; k++) begin
      id = $urandom_range(N - 1, 0);
      op_a[id] = 8'($urandom_range(255, 0));
      op_b[id] = 8'($urandom_range(255, 0));
      oh = N'(1) << id;
      step(1'b0, oh, 1'b1, oh, 1'b0, "rand");
      step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "rand_rsp");
    end

    // 4. fairness from a fresh reset, all requesters held valid
    for (int i = 0; i < N; i++) begin
      op_a[i] = 8'($urandom_range(255, 0));
      op_b[i] = 8'($urandom_range(255, 0));
    end
`ifdef ADD_ARB_FIXED_PRIO_EN
    fair_order = '{0, 0, 0, 0, 0, 0};
`else
    fair_order = '{0, 1, 2, 3, 0, 1};
`endif
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "rst2");
    for (int k = 0; k < 6; k++) begin
      oh = N'(1) << fair_order[k];
      step(1'b0, 4'b1111, 1'b1, oh, 1'b0, "fair");
      step(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, "fair_rsp");
    end

    // 5. backpressure: grant requester 1, stall 5 cycles with requester 3 waiting
    op_a[1] = 8'd150; op_b[1] = 8'd120;
    step(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, "bp_grant");
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, "bp_stall");
      check("bp_sum", 32'(rsp_sum), 32'(exp_q[0][7:0]));
      check("bp_c_out", 32'(rsp_c_out), 32'(exp_q[0][8]));
      check("bp_id", 32'(rsp_id), 32'(exp_q[0][EW-1:9]));
    end
    step(1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1, "bp_accept");
    step(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, "bp_next");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "bp_next_rsp");

    // 6. reset while a result is pending
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, "rm_grant");
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, "rm_hold");
    step(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, "rm_rst_in");
    step(1'b1, 4'b1010, 1'b1, 4'b0000, 1'b0, "rm_dropped");
    void'(exp_q.pop_front());
    n_push--;
    step(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b0, "rm_first");
    step(1'b0, 4'b1010, 1'b1, 4'b0000, 1'b1, "rm_first_rsp");
`ifdef ADD_ARB_FIXED_PRIO_EN
    step(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b0, "rm_second");
`else
    step(1'b0, 4'b1010, 1'b1, 4'b1000, 1'b0, "rm_second");
`endif
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "rm_second_rsp");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "idle_end");

    // final report
    check("q_empty", 32'(exp_q.size()), 32'(0));
    check("rsp_count", 32'(n_rsp), 32'(n_push));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
